// File: rtl/ls193_seq_pkg.sv
// ls193_seq_pkg
// Shared definitions for the LS193 command sequencer: command opcode
// encodings and the sequencer state enumeration.
package ls193_seq_pkg;

    // Command opcodes carried on CMD_OP
    localparam logic [1:0] OP_CLR  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLRP   = 3'd1,
        ST_LOADP  = 3'd2,
        ST_LOW    = 3'd3,
        ST_HIGH   = 3'd4,
        ST_SETTLE = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

endpackage

// File: rtl/ls193_seq_sync.sv
// ls193_seq_sync
// Two-flop synchroniser of parameterised width for asynchronous counter
// outputs, with an optional registered falling-edge detector that compares
// the second and third flop stages.
// Ports:
//   clk      in   clock, rising edge
//   rst_bar  in   synchronous active-low reset (flops load RST_VAL)
//   d        in   W  asynchronous input
//   q        out  W  synchronised value (second flop)
//   fall     out  W  one-cycle pulse per 1->0 transition (zero when EDGE=0)
module ls193_seq_sync
    import ls193_seq_pkg::*;
#(
    parameter int             W       = 1,
    parameter bit             EDGE    = 1'b0,
    parameter logic [W-1:0]   RST_VAL = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_bar,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] fall
);

    logic [W-1:0] s1_r;
    logic [W-1:0] s2_r;

    // Metastability-hardening flop pair
    always_ff @(posedge clk) begin
        if (!rst_bar) begin
            s1_r <= RST_VAL;
            s2_r <= RST_VAL;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
        end
    end

    assign q = s2_r;

    generate
        if (EDGE) begin : g_edge
            logic [W-1:0] s3_r;
            logic [W-1:0] fall_r;

            // Third stage plus registered falling-edge detect (old high, new low)
            always_ff @(posedge clk) begin
                if (!rst_bar) begin
                    s3_r   <= RST_VAL;
                    fall_r <= {W{1'b0}};
                end else begin
                    s3_r   <= s2_r;
                    fall_r <= s3_r & ~s2_r;
                end
            end

            assign fall = fall_r;
        end else begin : g_no_edge
            assign fall = {W{1'b0}};
        end
    endgenerate

endmodule

// File: rtl/ls193_sequencer.sv
// ls193_sequencer
// Command sequencer for one LS193 up/down counter. Accepts clear, load,
// count-up and count-down commands over a valid/ready handshake, produces
// clock-timed registered pulses on the counter pins, and reports the
// synchronised final count and the number of carry/borrow events.
// Ports:
//   CLK, RST_Bar              clock / synchronous active-low reset
//   CMD_VALID, CMD_READY      command handshake (READY only in IDLE)
//   CMD_OP, CMD_DATA, CMD_COUNT  opcode, load value, pulse count
//   CLR, LOAD_Bar, UP, DOWN   counter control pins (registered)
//   PRESET                    counter preset data, held between loads
//   Q, CO_Bar, BO_Bar         asynchronous counter outputs
//   DONE, WRAPS, Q_LAST       completion pulse, carry/borrow count, final Q
module ls193_sequencer
    import ls193_seq_pkg::*;
#(
    parameter int PW  = 2,
    parameter int GAP = 2,
    parameter int NW  = 8
) (
    input  logic          CLK,
    input  logic          RST_Bar,
    input  logic          CMD_VALID,
    output logic          CMD_READY,
    input  logic [1:0]    CMD_OP,
    input  logic [3:0]    CMD_DATA,
    input  logic [NW-1:0] CMD_COUNT,
    output logic          CLR,
    output logic          LOAD_Bar,
    output logic          UP,
    output logic          DOWN,
    output logic [3:0]    PRESET,
    input  logic [3:0]    Q,
    input  logic          CO_Bar,
    input  logic          BO_Bar,
    output logic          DONE,
    output logic [NW-1:0] WRAPS,
    output logic [3:0]    Q_LAST
);

    localparam int TMAX = (PW > GAP) ? PW : GAP;
    localparam int TW   = $clog2(TMAX + 1);

    localparam logic [TW-1:0] T_ZERO      = {TW{1'b0}};
    localparam logic [TW-1:0] T_ONE       = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0] PW_LAST     = TW'(PW - 1);
    localparam logic [TW-1:0] GAP_LAST    = TW'(GAP - 1);
    localparam logic [NW-1:0] N_ZERO      = {NW{1'b0}};
    localparam logic [NW-1:0] N_ONE       = {{(NW-1){1'b0}}, 1'b1};
    localparam logic [NW-1:0] N_MAX       = {NW{1'b1}};

    state_t          state_r, state_nxt;
    logic [TW-1:0]   timer_r, timer_nxt;
    logic [NW-1:0]   rem_r, rem_nxt;
    logic [1:0]      op_r, op_nxt;
    logic            accept_s;
    logic            qlast_load_s;

    logic            clr_r, clr_nxt;
    logic            load_bar_r, load_bar_nxt;
    logic            up_r, up_nxt;
    logic            down_r, down_nxt;
    logic            ready_r, ready_nxt;
    logic            done_r, done_nxt;
    logic [3:0]      preset_r;
    logic [NW-1:0]   wraps_r;
    logic [3:0]      q_last_r;

    logic [3:0]      q_sync_s;
    logic [3:0]      q_fall_unused_s;
    logic            co_sync_unused_s;
    logic            bo_sync_unused_s;
    logic            co_fall_s;
    logic            bo_fall_s;
    logic            wrap_event_s;

    ls193_seq_sync #(.W(4), .EDGE(1'b0), .RST_VAL(4'h0)) u_sync_q (
        .clk     (CLK),
        .rst_bar (RST_Bar),
        .d       (Q),
        .q       (q_sync_s),
        .fall    (q_fall_unused_s)
    );

    ls193_seq_sync #(.W(1), .EDGE(1'b1), .RST_VAL(1'b1)) u_sync_co (
        .clk     (CLK),
        .rst_bar (RST_Bar),
        .d       (CO_Bar),
        .q       (co_sync_unused_s),
        .fall    (co_fall_s)
    );

    ls193_seq_sync #(.W(1), .EDGE(1'b1), .RST_VAL(1'b1)) u_sync_bo (
        .clk     (CLK),
        .rst_bar (RST_Bar),
        .d       (BO_Bar),
        .q       (bo_sync_unused_s),
        .fall    (bo_fall_s)
    );

    // Next-state, timer, remaining-count and next pin values
    always_comb begin
        state_nxt    = state_r;
        timer_nxt    = timer_r + T_ONE;
        rem_nxt      = rem_r;
        op_nxt       = op_r;
        accept_s     = 1'b0;
        qlast_load_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                timer_nxt = T_ZERO;
                if (CMD_VALID) begin
                    accept_s = 1'b1;
                    op_nxt   = CMD_OP;
                    rem_nxt  = CMD_COUNT;
                    case (CMD_OP)
                        OP_CLR:  state_nxt = ST_CLRP;
                        OP_LOAD: state_nxt = ST_LOADP;
                        default: begin
                            if (CMD_COUNT != N_ZERO) begin
                                state_nxt = ST_LOW;
                            end else begin
                                state_nxt = ST_SETTLE;
                            end
                        end
                    endcase
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_CLRP, ST_LOADP: begin
                if (timer_r == PW_LAST) begin
                    state_nxt = ST_SETTLE;
                    timer_nxt = T_ZERO;
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_LOW: begin
                if (timer_r == PW_LAST) begin
                    state_nxt = ST_HIGH;
                    timer_nxt = T_ZERO;
                    rem_nxt   = rem_r - N_ONE;
                end else begin
                    state_nxt = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (timer_r == GAP_LAST) begin
                    timer_nxt = T_ZERO;
                    if (rem_r != N_ZERO) begin
                        state_nxt = ST_LOW;
                    end else begin
                        state_nxt = ST_SETTLE;
                    end
                end else begin
                    state_nxt = ST_HIGH;
                end
            end
            ST_SETTLE: begin
                // Two cycles let the last Q change reach the synchroniser output
                if (timer_r == T_ONE) begin
                    state_nxt    = ST_DONE;
                    timer_nxt    = T_ZERO;
                    qlast_load_s = 1'b1;
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                timer_nxt = T_ZERO;
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = T_ZERO;
            end
        endcase

        // Pins are decoded from the next state so they switch on the same
        // edge as the state register; op_nxt keeps UP/DOWN exclusive.
        clr_nxt      = (state_nxt == ST_CLRP);
        load_bar_nxt = (state_nxt != ST_LOADP);
        up_nxt       = !((state_nxt == ST_LOW) && (op_nxt == OP_UP));
        down_nxt     = !((state_nxt == ST_LOW) && (op_nxt == OP_DOWN));
        ready_nxt    = (state_nxt == ST_IDLE);
        done_nxt     = (state_nxt == ST_DONE);
    end

    // Only carry edges count during up, only borrow edges during down
    always_comb begin
        if (state_r != ST_IDLE) begin
            wrap_event_s = ((op_r == OP_UP)   && co_fall_s) ||
                           ((op_r == OP_DOWN) && bo_fall_s);
        end else begin
            wrap_event_s = 1'b0;
        end
    end

    // FSM state, timer, latched command and registered pins
    always_ff @(posedge CLK) begin
        if (!RST_Bar) begin
            state_r    <= ST_IDLE;
            timer_r    <= T_ZERO;
            rem_r      <= N_ZERO;
            op_r       <= OP_CLR;
            clr_r      <= 1'b0;
            load_bar_r <= 1'b1;
            up_r       <= 1'b1;
            down_r     <= 1'b1;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt;
            timer_r    <= timer_nxt;
            rem_r      <= rem_nxt;
            op_r       <= op_nxt;
            clr_r      <= clr_nxt;
            load_bar_r <= load_bar_nxt;
            up_r       <= up_nxt;
            down_r     <= down_nxt;
            ready_r    <= ready_nxt;
            done_r     <= done_nxt;
        end
    end

    // Preset data, saturating carry/borrow counter and final-count capture
    always_ff @(posedge CLK) begin
        if (!RST_Bar) begin
            preset_r <= 4'h0;
            wraps_r  <= N_ZERO;
            q_last_r <= 4'h0;
        end else begin
            if (accept_s && (CMD_OP == OP_LOAD)) begin
                preset_r <= CMD_DATA;
            end
            if (accept_s) begin
                wraps_r <= N_ZERO;
            end else if (wrap_event_s && (wraps_r != N_MAX)) begin
                wraps_r <= wraps_r + N_ONE;
            end
            if (qlast_load_s) begin
                q_last_r <= q_sync_s;
            end
        end
    end

    assign CMD_READY = ready_r;
    assign CLR       = clr_r;
    assign LOAD_Bar  = load_bar_r;
    assign UP        = up_r;
    assign DOWN      = down_r;
    assign PRESET    = preset_r;
    assign DONE      = done_r;
    assign WRAPS     = wraps_r;
    assign Q_LAST    = q_last_r;

endmodule

// File: tb/tb_ls193_sequencer.sv
// Testbench for ls193_sequencer with a behavioural LS193 counter model and
// a queue of expected per-command results.
module tb_ls193_sequencer;

    localparam int PW  = 2;
    localparam int GAP = 2;
    localparam int NW  = 8;

    logic          CLK = 1'b0;
    logic          RST_Bar = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [1:0]    CMD_OP = 2'b00;
    logic [3:0]    CMD_DATA = 4'h0;
    logic [NW-1:0] CMD_COUNT = '0;
    logic          CLR, LOAD_Bar, UP, DOWN, DONE;
    logic [3:0]    PRESET, Q_LAST;
    logic [NW-1:0] WRAPS;
    logic          CO_Bar, BO_Bar;

    // Behavioural LS193: async clear/load, counts on rising UP/DOWN
    logic [3:0] q_m = 4'h0;
    logic       up_prev = 1'b1;
    logic       dn_prev = 1'b1;

    always @(UP or DOWN or CLR or LOAD_Bar or PRESET) begin
        if (CLR) begin
            q_m = 4'h0;
        end else if (!LOAD_Bar) begin
            q_m = PRESET;
        end else begin
            if (UP && !up_prev) q_m = q_m + 4'h1;
            if (DOWN && !dn_prev) q_m = q_m - 4'h1;
        end
        up_prev = UP;
        dn_prev = DOWN;
    end

    assign CO_Bar = ~(~UP & (q_m == 4'hF));
    assign BO_Bar = ~(~DOWN & (q_m == 4'h0));

    ls193_sequencer #(.PW(PW), .GAP(GAP), .NW(NW)) dut (
        .CLK       (CLK),
        .RST_Bar   (RST_Bar),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_DATA  (CMD_DATA),
        .CMD_COUNT (CMD_COUNT),
        .CLR       (CLR),
        .LOAD_Bar  (LOAD_Bar),
        .UP        (UP),
        .DOWN      (DOWN),
        .PRESET    (PRESET),
        .Q         (q_m),
        .CO_Bar    (CO_Bar),
        .BO_Bar    (BO_Bar),
        .DONE      (DONE),
        .WRAPS     (WRAPS),
        .Q_LAST    (Q_LAST)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] op;
        int         n;
        int         done_edge;
        int         q_last;
        int         wraps;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one command, watch pins until DONE, then score against the queue
    task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input int n,
                           input int exp_q, input int exp_wraps, input bit hold_valid);
        exp_t e;
        exp_t got;
        int   edge_i;
        int   up_low, dn_low, clr_hi, ld_low, up_falls, dn_falls, ready_hi, overlap;
        logic prev_up, prev_dn;
        bit   got_done;
        up_low = 0; dn_low = 0; clr_hi = 0; ld_low = 0;
        up_falls = 0; dn_falls = 0; ready_hi = 0; overlap = 0;
        got_done = 1'b0;

        @(negedge CLK);
        chk("ready_before", 32'(CMD_READY), 32'd1);
        CMD_VALID = 1'b1;
        CMD_OP    = op;
        CMD_DATA  = data;
        CMD_COUNT = NW'(n);
        e.op        = op;
        e.n         = n;
        e.done_edge = op[1] ? n * (PW + GAP) + 2 : PW + 2;
        e.q_last    = exp_q;
        e.wraps     = exp_wraps;
        sb_q.push_back(e);
        prev_up = UP;
        prev_dn = DOWN;

        @(posedge CLK);
        edge_i = 0;
        if (!hold_valid) #1 CMD_VALID = 1'b0;

        while (!got_done && edge_i < 2000) begin
            @(negedge CLK);
            if (!UP) up_low++;
            if (!DOWN) dn_low++;
            if (CLR) clr_hi++;
            if (!LOAD_Bar) ld_low++;
            if (prev_up && !UP) up_falls++;
            if (prev_dn && !DOWN) dn_falls++;
            if ((!UP && !DOWN) || (CLR && !LOAD_Bar)) overlap++;
            if (CMD_READY) ready_hi++;
            prev_up = UP;
            prev_dn = DOWN;
            if (DONE) begin
                got_done = 1'b1;
            end else begin
                @(posedge CLK);
                edge_i++;
            end
        end
        CMD_VALID = 1'b0;

        got = sb_q.pop_front();
        chk("done_seen", 32'(got_done), 32'd1);
        chk("done_edge", edge_i, got.done_edge);
        chk("q_last", 32'(Q_LAST), got.q_last);
        chk("wraps", 32'(WRAPS), got.wraps);
        chk("up_falls", up_falls, (got.op == 2'b10) ? got.n : 0);
        chk("up_low_cycles", up_low, (got.op == 2'b10) ? got.n * PW : 0);
        chk("down_falls", dn_falls, (got.op == 2'b11) ? got.n : 0);
        chk("down_low_cycles", dn_low, (got.op == 2'b11) ? got.n * PW : 0);
        chk("clr_high_cycles", clr_hi, (got.op == 2'b00) ? PW : 0);
        chk("load_low_cycles", ld_low, (got.op == 2'b01) ? PW : 0);
        chk("pin_overlap", overlap, 0);
        chk("ready_busy", ready_hi, 0);

        @(negedge CLK);
        chk("done_one_cycle", 32'(DONE), 32'd0);
        chk("ready_after", 32'(CMD_READY), 32'd1);
    endtask

    initial begin
        int done_cnt;
        int ready_lo;

        // Reset state
        RST_Bar = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_up", 32'(UP), 32'd1);
        chk("rst_down", 32'(DOWN), 32'd1);
        chk("rst_load_bar", 32'(LOAD_Bar), 32'd1);
        chk("rst_clr", 32'(CLR), 32'd0);
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_wraps", 32'(WRAPS), 32'd0);
        chk("rst_q_last", 32'(Q_LAST), 32'd0);
        chk("rst_preset", 32'(PRESET), 32'd0);
        RST_Bar = 1'b1;

        run_cmd(2'b00, 4'h0, 0, 0, 0, 1'b0);      // clear
        run_cmd(2'b01, 4'hD, 0, 13, 0, 1'b0);     // load D
        run_cmd(2'b10, 4'h0, 5, 2, 1, 1'b0);      // up 5: D..F,0,1,2
        chk("preset_held", 32'(PRESET), 32'hD);
        run_cmd(2'b01, 4'h1, 0, 1, 0, 1'b0);      // load 1
        run_cmd(2'b11, 4'h0, 3, 14, 1, 1'b0);     // down 3: 0,F,E
        run_cmd(2'b10, 4'h0, 0, 14, 0, 1'b0);     // up 0: no pulse
        run_cmd(2'b00, 4'h0, 0, 0, 0, 1'b0);      // clear
        run_cmd(2'b10, 4'h0, 40, 8, 2, 1'b1);     // up 40, valid held
        run_cmd(2'b01, 4'h5, 0, 5, 0, 1'b0);      // load 5

        // Reset during the third UP low pulse (edges 8..9 of an up-5)
        @(negedge CLK);
        CMD_VALID = 1'b1;
        CMD_OP    = 2'b10;
        CMD_COUNT = NW'(5);
        @(posedge CLK);
        #1 CMD_VALID = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        chk("pre_rst_up_low", 32'(UP), 32'd0);
        RST_Bar = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("mid_rst_up", 32'(UP), 32'd1);
        chk("mid_rst_down", 32'(DOWN), 32'd1);
        chk("mid_rst_clr", 32'(CLR), 32'd0);
        chk("mid_rst_load_bar", 32'(LOAD_Bar), 32'd1);
        chk("mid_rst_ready", 32'(CMD_READY), 32'd1);
        chk("mid_rst_done", 32'(DONE), 32'd0);
        chk("mid_rst_q_last", 32'(Q_LAST), 32'd0);
        chk("mid_rst_preset", 32'(PRESET), 32'd0);
        RST_Bar = 1'b1;
        done_cnt = 0;
        ready_lo = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (DONE) done_cnt++;
            if (!CMD_READY) ready_lo++;
        end
        chk("post_rst_no_done", done_cnt, 0);
        chk("post_rst_ready", ready_lo, 0);
        chk("scoreboard_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
